// File: rtl/sw_fifo_arb.sv
// sw_fifo_arb: two-requester round-robin FIFO controller over a 32x12 two-port SRAM
// with a 2-entry show-ahead output buffer.
module sw_fifo_arb #(
    parameter int DW = 12,
    parameter int AW = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          w0_valid,
    input  logic [DW-1:0] w0_data,
    output logic          w0_ready,
    input  logic          w1_valid,
    input  logic [DW-1:0] w1_data,
    output logic          w1_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic [AW+1:0] level,
    output logic          full,
    output logic [AW-1:0] mem_wa,
    output logic [DW-1:0] mem_di,
    output logic          mem_csa,
    output logic          mem_web,
    output logic [AW-1:0] mem_rb,
    output logic          mem_csb,
    output logic          mem_oe,
    input  logic [DW-1:0] mem_do
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] sram_cnt;
    logic inflight, rr, oe;
    logic [1:0] bcnt, n;
    logic [DW-1:0] b0, b1, b0_n, b1_n;
    logic allow, g0, g1, wr, pop, issue;
    // Accept/issue decisions use only registered counts, so a read never targets the word being written.
    always_comb begin
        allow = rst_n & ~flush & (sram_cnt < FULL_CNT);
        g0 = allow & w0_valid & (~w1_valid | ~rr);
        g1 = allow & w1_valid & (~w0_valid | rr);
        wr = g0 | g1;
        pop = rd_valid & rd_ready;
        issue = rst_n & ~flush & (sram_cnt != '0) &
                (({1'b0, bcnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
        n = bcnt - {1'b0, pop};
        b0_n = (inflight && n == 2'd0) ? mem_do : pop ? b1 : b0;
        b1_n = (inflight && n != 2'd0) ? mem_do : b1;
    end
    assign w0_ready = g0;
    assign w1_ready = g1;
    assign rd_valid = bcnt != 2'd0;
    assign rd_data = b0;
    assign level = {1'b0, sram_cnt} + {{AW{1'b0}}, bcnt} + {{(AW+1){1'b0}}, inflight};
    assign full = sram_cnt == FULL_CNT;
    assign mem_wa = wr_ptr;
    assign mem_di = g1 ? w1_data : g0 ? w0_data : '0;
    assign mem_csa = wr;
    assign mem_web = ~wr;
    assign mem_rb = rd_ptr;
    assign mem_csb = issue;
    assign mem_oe = oe;
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
            bcnt <= 2'd0;
            b0 <= '0;
            b1 <= '0;
            rr <= 1'b0;
            oe <= rst_n;
        end else begin
            oe <= 1'b1;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            sram_cnt <= sram_cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, issue};
            inflight <= issue;
            bcnt <= n + {1'b0, inflight};
            b0 <= b0_n;
            b1 <= b1_n;
            if (allow && w0_valid && w1_valid) rr <= ~rr;
        end
    end
endmodule
